reg_writeback_sequencer: RTL and testbench
==========================================

Name: reg_writeback_sequencer

Overview:
- Writer side of the 32x32 register file write port: sole driver of RegWrite/A3/WD3.
- Merges two writeback sources: single-cycle ALU results (never stalled) and variable-latency memory/multiply results (valid/ready handshake, buffered in a small FIFO).
- Exports pending-write status so decode can stall on operands whose writes are still queued.

Parameters:
- DEPTH, 4, FIFO entries for the memory source; power of two, at least 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alu_we  in  1  ALU writeback request this cycle
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mem_valid  in  1  memory-source result valid
- mem_ready  out  1  sequencer can accept a memory result
- mem_addr  in  AW  memory-source destination register
- mem_data  in  DW  memory-source result
- q_addr1  in  AW  decode operand 1 query
- q_addr2  in  AW  decode operand 2 query
- q_pend1  out  1  live queued write pending to q_addr1
- q_pend2  out  1  live queued write pending to q_addr2
- fifo_count  out  clog2(DEPTH)+1  occupied FIFO entries
- RegWrite  out  1  register-file write enable (registered)
- A3  out  AW  register-file write address (registered)
- WD3  out  DW  register-file write data (registered)

Behaviour:
- Reset, synchronous, overrides all else, including mid-drain:
  - RegWrite=0, A3=0, WD3=0, count=0, read/write pointers=0, all entry live bits=0.
  - Queued data is discarded.
  - mem_ready=1 in the first cycle after reset.
- Output stage latency:
  - A request presented in cycle N drives RegWrite/A3/WD3 in cycle N+1.
  - The register file commits the write at the end of N+1; its read bypass covers that cycle.
- Memory handshake:
  - Transfer occurs when mem_valid && mem_ready.
  - mem_ready = (count < DEPTH). It is derived from registered count only and never depends on mem_valid.
  - When full, mem_ready=0 even if a pop occurs that cycle.
  - Source holds mem_addr/mem_data stable until the transfer completes.
- Enqueue on transfer: store {addr, data, live}.
  - live=0 if mem_addr==0.
  - live=0 if alu_we && alu_addr==mem_addr in the same cycle (the ALU write is younger in program order and wins).
  - Otherwise live=1.
- ALU priority:
  - ALU write is issued when alu_we && alu_addr!=0. It loads the output stage with RegWrite=1.
  - Any live FIFO entry whose addr equals alu_addr has its live bit cleared in the same cycle (WAW kill).
- FIFO drain, when no ALU write is issued and count>0: pop the head.
  - Head live: output RegWrite=1, A3=head addr, WD3=head data.
  - Head dead: output RegWrite=0. A3/WD3 hold their previous values.
- Otherwise (no ALU write, FIFO empty): RegWrite=0; A3/WD3 hold.
- Pointers and count:
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Count never exceeds DEPTH or goes below 0.
- Pending query:
  - q_pendN=1 iff q_addrN!=0 and some occupied, live entry has addr==q_addrN.
  - Combinational from registered state only.
  - The output-stage write is not reported as pending, since the register file bypasses it.
- Register 0 is never written: RegWrite is never 1 with A3==0.

Decomposition:
- Shared package: AW/DW defaults and the REG_ZERO constant (0).
- One natural sub-module: wb_fifo. It holds the DEPTH-entry storage with pointers, count, per-entry live bits, a kill-by-address port and a match-by-address query.
- The top level holds priority selection, the output register and the handshake.

Test Plan:
- Reset mid-drain: enqueue 3 entries, assert reset for 1 cycle -> next cycle fifo_count=0, RegWrite=0, A3=0, WD3=0, mem_ready=1, q_pend1=0.
- ALU priority: alu_we=1 (r5=0x11) each cycle for 3 cycles, memory result r6=0x22 enqueued at cycle 0 -> writes r5 at cycles 1-3. r6=0x22 written at cycle 4. q_pend1 (q_addr1=6) is 1 through cycle 3, 0 at cycle 4.
- Full FIFO: hold alu_we=1 and push 4 memory results -> fifo_count=4, mem_ready=0. A fifth mem_valid is not accepted until a pop. Drop alu_we -> FIFO drains in order, one write per cycle, pointers wrap.
- WAW kill: queue r7=0xAA, then ALU writes r7=0xBB -> output r7=0xBB. The later pop of r7 yields RegWrite=0. q_pend(7) clears in the cycle after the ALU issue.
- Same-cycle collision: mem r9=0x1 and ALU r9=0x2 in one cycle -> only r9=0x2 is written. The entry is enqueued dead and its pop gives RegWrite=0.
- Zero register: alu_we=1 with addr 0, plus memory result to addr 0 -> RegWrite stays 0 throughout, with no A3=0 write. q_pend for addr 0 is always 0.

Source files
------------

// File: rtl/reg_writeback_sequencer_pkg.sv
// Shared constants for the register-file writeback sequencer.
// Register 0 is hardwired and must never be the target of a write.
package reg_writeback_sequencer_pkg;
  localparam int AW_DEF    = 5;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int REG_ZERO  = 0;
endpackage

// File: rtl/reg_writeback_sequencer_if.sv
// Writeback sources, decode pending queries and register-file write port.
// slave is the sequencer side; master is the environment driving it.
interface reg_writeback_sequencer_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_we;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] q_addr1;
  logic [AW-1:0] q_addr2;
  logic          q_pend1;
  logic          q_pend2;
  logic [CW-1:0] fifo_count;
  logic          RegWrite;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;

  modport slave (
    input  alu_we, alu_addr, alu_data, mem_valid, mem_addr, mem_data, q_addr1, q_addr2,
    output mem_ready, q_pend1, q_pend2, fifo_count, RegWrite, A3, WD3
  );

  modport master (
    output alu_we, alu_addr, alu_data, mem_valid, mem_addr, mem_data, q_addr1, q_addr2,
    input  mem_ready, q_pend1, q_pend2, fifo_count, RegWrite, A3, WD3
  );
endinterface

// File: rtl/reg_writeback_sequencer_wb_fifo.sv
// DEPTH-entry writeback queue with per-entry live bits, address kill and
// address match queries. Occupancy is derived from pointers and count.
module reg_writeback_sequencer_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          push_live,
  input  logic          pop,
  input  logic          kill,
  input  logic [AW-1:0] kill_addr,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          head_live,
  output logic [CW-1:0] count,
  output logic          q_match1,
  output logic          q_match2
);
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic [PW-1:0]    off;

  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    occupied = '0;
    hit1     = '0;
    hit2     = '0;
    off      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PW'(i) - rd_ptr;
      occupied[i] = {1'b0, off} < count_q;
      hit1[i]     = addr_q[i] == q_addr1;
      hit2[i]     = addr_q[i] == q_addr2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && occupied[i] && addr_q[i] == kill_addr) live_q[i] <= 1'b0;
      end
      if (push) begin
        live_q[wr_ptr] <= push_live;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_live = live_q[rd_ptr];
  assign count     = count_q;
  assign q_match1  = |(occupied & live_q & hit1);
  assign q_match2  = |(occupied & live_q & hit2);
endmodule

// File: rtl/reg_writeback_sequencer.sv
// Sole writer of the register-file port: ALU results take priority, queued
// memory/multiply results drain when the ALU is idle.
module reg_writeback_sequencer
  import reg_writeback_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input logic                      clk,
  input logic                      reset,
  reg_writeback_sequencer_if.slave bus
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic          alu_issue;
  logic          push;
  logic          push_live;
  logic          pop;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          head_live;
  logic [CW-1:0] count;
  logic          q_match1;
  logic          q_match2;
  logic          reg_we;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;

  assign alu_issue     = bus.alu_we && bus.alu_addr != ZERO;
  assign bus.mem_ready = count < CW'(DEPTH);
  assign push          = bus.mem_valid && bus.mem_ready;
  // A same-cycle ALU write to the same register is younger and supersedes it.
  assign push_live     = bus.mem_addr != ZERO && !(bus.alu_we && bus.alu_addr == bus.mem_addr);
  assign pop           = !alu_issue && count != '0;

  reg_writeback_sequencer_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.mem_addr),
    .push_data (bus.mem_data),
    .push_live (push_live),
    .pop       (pop),
    .kill      (alu_issue),
    .kill_addr (bus.alu_addr),
    .q_addr1   (bus.q_addr1),
    .q_addr2   (bus.q_addr2),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_live (head_live),
    .count     (count),
    .q_match1  (q_match1),
    .q_match2  (q_match2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_we   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
    end else if (alu_issue) begin
      reg_we   <= 1'b1;
      reg_addr <= bus.alu_addr;
      reg_data <= bus.alu_data;
    end else if (pop && head_live) begin
      reg_we   <= 1'b1;
      reg_addr <= head_addr;
      reg_data <= head_data;
    end else begin
      reg_we   <= 1'b0;
    end
  end

  assign bus.RegWrite   = reg_we;
  assign bus.A3         = reg_addr;
  assign bus.WD3        = reg_data;
  assign bus.fifo_count = count;
  assign bus.q_pend1    = bus.q_addr1 != ZERO && q_match1;
  assign bus.q_pend2    = bus.q_addr2 != ZERO && q_match2;
endmodule

// File: tb/tb_reg_writeback_sequencer.sv
// Directed plus randomized bench for reg_writeback_sequencer against a
// queue-based reference model of the writeback rules.
module tb_reg_writeback_sequencer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  ent_t        mq[$];
  bit          e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd3;
  bit          last_xfer;

  reg_writeback_sequencer_if #(.AW(5), .DW(32), .DEPTH(DEPTH)) bus ();

  reg_writeback_sequencer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend(logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_in(bit awe, int aa, int ad, bit mv, int ma, int md);
    bus.alu_we    = awe;
    bus.alu_addr  = 5'(aa);
    bus.alu_data  = 32'(ad);
    bus.mem_valid = mv;
    bus.mem_addr  = 5'(ma);
    bus.mem_data  = 32'(md);
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, check all outputs.
  task automatic step(string tag);
    bit   issue;
    bit   xfer;
    ent_t e;
    @(posedge clk);
    xfer = 1'b0;
    if (reset) begin
      mq.delete();
      e_we  = 1'b0;
      e_a3  = '0;
      e_wd3 = '0;
    end else begin
      issue = bus.alu_we && bus.alu_addr != 5'd0;
      xfer  = bus.mem_valid && (mq.size() < DEPTH);
      if (issue) begin
        foreach (mq[i]) if (mq[i].addr == bus.alu_addr) mq[i].live = 1'b0;
        e_we  = 1'b1;
        e_a3  = bus.alu_addr;
        e_wd3 = bus.alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        e_we = e.live;
        if (e.live) begin
          e_a3  = e.addr;
          e_wd3 = e.data;
        end
      end else begin
        e_we = 1'b0;
      end
      if (xfer) begin
        e.addr = bus.mem_addr;
        e.data = bus.mem_data;
        e.live = bus.mem_addr != 5'd0 && !(bus.alu_we && bus.alu_addr == bus.mem_addr);
        mq.push_back(e);
      end
    end
    last_xfer = xfer;
    #1;
    chk({tag, ":count"}, bus.fifo_count, mq.size());
    chk({tag, ":we"}, bus.RegWrite, e_we);
    chk({tag, ":a3"}, bus.A3, e_a3);
    chk({tag, ":wd3"}, bus.WD3, e_wd3);
    chk({tag, ":ready"}, bus.mem_ready, mq.size() < DEPTH);
    chk({tag, ":pend1"}, bus.q_pend1, pend(bus.q_addr1));
    chk({tag, ":pend2"}, bus.q_pend2, pend(bus.q_addr2));
    chk({tag, ":r0"}, bus.RegWrite && bus.A3 == 5'd0, 1'b0);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    last_xfer = 1'b0;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    bus.q_addr1 = '0;
    bus.q_addr2 = '0;
    step("rst");
    chk("rst_ready", bus.mem_ready, 1'b1);
    reset = 1'b0;

    // reset in the middle of a drain
    set_in(1, 10, 'h10, 1, 1, 'h101); step("rmd0");
    set_in(1, 10, 'h10, 1, 2, 'h102); step("rmd1");
    set_in(1, 11, 'h11, 1, 3, 'h103); step("rmd2");
    chk("rmd_count3", bus.fifo_count, 3);
    set_in(0, 0, 0, 0, 0, 0);         step("rmd3");
    reset = 1'b1;
    bus.q_addr1 = 5'd2;
    step("rmd_rst");
    chk("rmd_cnt0", bus.fifo_count, 0);
    chk("rmd_we0", bus.RegWrite, 0);
    chk("rmd_a30", bus.A3, 0);
    chk("rmd_wd30", bus.WD3, 0);
    chk("rmd_ready1", bus.mem_ready, 1);
    chk("rmd_pend0", bus.q_pend1, 0);
    reset = 1'b0;

    // ALU priority over a queued memory result
    bus.q_addr1 = 5'd6;
    set_in(1, 5, 'h11, 1, 6, 'h22); step("ap0");
    chk("ap_c1_a3", bus.A3, 5);
    chk("ap_c1_pend", bus.q_pend1, 1);
    set_in(1, 5, 'h11, 0, 0, 0);    step("ap1");
    set_in(1, 5, 'h11, 0, 0, 0);    step("ap2");
    chk("ap_c3_pend", bus.q_pend1, 1);
    set_in(0, 0, 0, 0, 0, 0);       step("ap3");
    chk("ap_c4_we", bus.RegWrite, 1);
    chk("ap_c4_a3", bus.A3, 6);
    chk("ap_c4_wd3", bus.WD3, 'h22);
    chk("ap_c4_pend", bus.q_pend1, 0);

    // fill the FIFO behind a busy ALU, then drain with wrap
    for (int i = 0; i < 4; i++) begin
      set_in(1, 12, 'h1200 + i, 1, i + 1, 'hA0 + i);
      step("full_fill");
    end
    chk("full_cnt4", bus.fifo_count, 4);
    chk("full_ready0", bus.mem_ready, 0);
    set_in(1, 12, 'h12FF, 1, 5, 'h55); step("full_hold0");
    set_in(1, 12, 'h12FF, 1, 5, 'h55); step("full_hold1");
    chk("full_cnt_still4", bus.fifo_count, 4);
    set_in(0, 0, 0, 1, 5, 'h55);       step("full_drain0");
    chk("full_first_a3", bus.A3, 1);
    set_in(0, 0, 0, 1, 5, 'h55);       step("full_drain1");
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("full_drain");
    chk("full_last_a3", bus.A3, 5);
    chk("full_last_wd3", bus.WD3, 'h55);

    // WAW kill of a queued entry
    bus.q_addr2 = 5'd7;
    set_in(0, 0, 0, 1, 7, 'hAA);  step("waw0");
    chk("waw_pend_set", bus.q_pend2, 1);
    set_in(1, 7, 'hBB, 0, 0, 0);  step("waw1");
    chk("waw_wd3", bus.WD3, 'hBB);
    chk("waw_pend_clr", bus.q_pend2, 0);
    set_in(0, 0, 0, 0, 0, 0);     step("waw2");
    chk("waw_dead_pop", bus.RegWrite, 0);

    // same-cycle collision
    set_in(1, 9, 'h2, 1, 9, 'h1); step("col0");
    chk("col_wd3", bus.WD3, 'h2);
    chk("col_cnt", bus.fifo_count, 1);
    set_in(0, 0, 0, 0, 0, 0);     step("col1");
    chk("col_dead_pop", bus.RegWrite, 0);

    // register zero
    bus.q_addr1 = 5'd0;
    set_in(1, 0, 'h33, 1, 0, 'h44); step("z0");
    chk("z_we0", bus.RegWrite, 0);
    set_in(0, 0, 0, 0, 0, 0);       step("z1");
    chk("z_we1", bus.RegWrite, 0);
    chk("z_pend", bus.q_pend1, 0);

    // randomized traffic; the memory source holds its beat until accepted
    last_xfer = 1'b1;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.alu_we   = ($urandom_range(0, 99) < 40);
      bus.alu_addr = 5'($urandom_range(0, 7));
      bus.alu_data = $urandom;
      if (!bus.mem_valid || last_xfer) begin
        bus.mem_valid = ($urandom_range(0, 99) < 60);
        bus.mem_addr  = 5'($urandom_range(0, 7));
        bus.mem_data  = $urandom;
      end
      bus.q_addr1 = 5'($urandom_range(0, 7));
      bus.q_addr2 = 5'($urandom_range(0, 7));
      step("rnd");
      if (reset) last_xfer = 1'b1;
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
